// File: rtl/zsdram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : zsdram_arbiter                                                  |
// | Purpose  : SDRAM front-end arbiter. It sequences power-up initialisation,  |
// |            inserts periodic auto-refresh, and grants client read/write     |
// |            requests round-robin.                                           |
// | Option   : ZSDRAM_REFRESH_POSTPONE_EN lets a pending refresh slip by up to |
// |            TPOSTPONE cycles while clients are requesting.                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module zsdram_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int TREF      = 600,
  parameter int TPOSTPONE = 200,
  parameter int CNT_W     = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] iWrReq,
  input  logic [NUM_CH-1:0] iRdReq,
  input  logic              iDone,
  output logic [3:0]        oReq,
  output logic [NUM_CH-1:0] oGrant,
  output logic [NUM_CH-1:0] oWrDone,
  output logic [NUM_CH-1:0] oRdDone
);

  localparam int         c_ptr_w    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int         c_cnt_need = TREF + TPOSTPONE;
  localparam logic [3:0] c_req_init = 4'b0001;
  localparam logic [3:0] c_req_ref  = 4'b0010;
  localparam logic [3:0] c_req_rd   = 4'b0100;
  localparam logic [3:0] c_req_wr   = 4'b1000;
  localparam logic [CNT_W-1:0] c_tref = CNT_W'(TREF);

  if (c_cnt_need >= (1 << CNT_W)) begin : g_cnt_w_too_small
    $error("zsdram_arbiter: CNT_W cannot hold TREF+TPOSTPONE");
  end

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_WRITE   = 3'd2,
    S_READ    = 3'd3,
    S_REFRESH = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          req_q, req_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic [NUM_CH-1:0]   wr_done_q, wr_done_d;
  logic [NUM_CH-1:0]   rd_done_q, rd_done_d;
  logic [c_ptr_w-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NUM_CH-1:0]   w_req_any;
  logic                w_found;
  logic [c_ptr_w-1:0]  w_win;
  logic [c_ptr_w:0]    w_sum;
  logic [c_ptr_w-1:0]  w_idx;
  logic [c_ptr_w-1:0]  w_ptr_next;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_pend;
  logic                w_refresh_go;

  assign w_req_any = iWrReq | iRdReq;

  // Scan channels starting at the round-robin pointer, wrapping modulo NUM_CH.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum = {1'b0, ptr_q} + (c_ptr_w + 1)'(i);
      if (w_sum >= (c_ptr_w + 1)'(NUM_CH)) begin
        w_sum = w_sum - (c_ptr_w + 1)'(NUM_CH);
      end
      w_idx = w_sum[c_ptr_w-1:0];
      if (!w_found && w_req_any[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_ptr_next = (w_win == c_ptr_w'(NUM_CH - 1)) ? '0 : w_win + 1'b1;
  assign w_cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign w_pend     = (cnt_q >= c_tref);

`ifdef ZSDRAM_REFRESH_POSTPONE_EN
  localparam logic [CNT_W-1:0] c_tlimit = CNT_W'(c_cnt_need);
  assign w_refresh_go = w_pend && (!w_found || (cnt_q >= c_tlimit));
`else
  assign w_refresh_go = w_pend;
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    grant_d   = grant_q;
    wr_done_d = '0;
    rd_done_d = '0;
    ptr_d     = ptr_q;
    cnt_d     = (state_q == S_INIT) ? cnt_q : w_cnt_inc;

    case (state_q)
      S_INIT: begin
        req_d = c_req_init;
        if (iDone) begin
          req_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (w_refresh_go) begin
          cnt_d   = '0;
          req_d   = c_req_ref;
          state_d = S_REFRESH;
        end else if (w_found) begin
          grant_d        = '0;
          grant_d[w_win] = 1'b1;
          ptr_d          = w_ptr_next;
          if (iWrReq[w_win]) begin
            req_d   = c_req_wr;
            state_d = S_WRITE;
          end else begin
            req_d   = c_req_rd;
            state_d = S_READ;
          end
        end
      end
      S_WRITE: begin
        if (iDone) begin
          req_d     = '0;
          wr_done_d = grant_q;
          state_d   = S_DONE;
        end
      end
      S_READ: begin
        if (iDone) begin
          req_d     = '0;
          rd_done_d = grant_q;
          state_d   = S_DONE;
        end
      end
      S_REFRESH: begin
        if (iDone) begin
          req_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        req_d   = '0;
        grant_d = '0;
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      req_q     <= '0;
      grant_q   <= '0;
      wr_done_q <= '0;
      rd_done_q <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      grant_q   <= grant_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign oReq    = req_q;
  assign oGrant  = grant_q;
  assign oWrDone = wr_done_q;
  assign oRdDone = rd_done_q;

endmodule
`default_nettype wire

// File: doc/zsdram_arbiter.md
Name: zsdram_arbiter

Overview:
- Parametrised SDRAM front-end arbiter between NUM_CH client ports and the SDRAM command core (init/refresh/read/write sequencers).
- Sequences power-up initialisation, then arbitrates client read/write requests round-robin.
- Inserts periodic auto-refresh from a programmable interval timer.
- Drives a one-hot grant so upstream address/data muxes select the winning client.

Parameters:
NUM_CH, 4, number of client channels (1..16)
TREF, 600, cycles between refreshes (80 MHz, 7.5 us)
TPOSTPONE, 200, extra cycles a refresh may be deferred (used only with the optional feature)
CNT_W, 11, refresh counter width; must hold TREF+TPOSTPONE

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
iWrReq  in  NUM_CH  per-channel write request, level, held until matching done
iRdReq  in  NUM_CH  per-channel read request, level, held until matching done
iDone  in  1  single-cycle completion pulse from the SDRAM core for the current oReq operation
oReq  out  4  one-hot core request: [0]=initial, [1]=refresh, [2]=read, [3]=write
oGrant  out  NUM_CH  one-hot granted channel, valid during READ/WRITE/DONE
oWrDone  out  NUM_CH  one-cycle write-complete pulse to granted channel
oRdDone  out  NUM_CH  one-cycle read-complete pulse to granted channel

Behaviour:
- Reset (async, rst=1): state=INIT, all outputs 0, refresh counter 0, round-robin pointer 0. Reset mid-operation aborts it with no done pulse.
- States: INIT, IDLE, WRITE, READ, REFRESH, DONE.
- INIT: oReq[0]=1 from the first edge after rst falls, until iDone. On iDone: oReq[0]=0, counter cleared, go to IDLE.
- Refresh counter: increments every cycle outside INIT and saturates at 2^CNT_W-1. pend = (cnt >= TREF).
- IDLE priority: pend first, then clients.
  - If pend: cnt<=0, go to REFRESH, oReq[1]<=1 on the same edge.
  - Otherwise the winner is the first channel c, scanning from ptr upward modulo NUM_CH, with iWrReq[c]|iRdReq[c].
  - Within a channel, write beats read.
  - On the same edge: oGrant[c]<=1, ptr<=(c+1) mod NUM_CH, and either oReq[3]<=1 (go to WRITE) or oReq[2]<=1 (go to READ).
- WRITE/READ/REFRESH: hold oReq until iDone is sampled high. On that edge the oReq bit clears.
  - REFRESH then goes to IDLE.
  - WRITE/READ go to DONE.
- DONE: oWrDone[c] or oRdDone[c] high for exactly one cycle, oGrant still held. Next edge: oGrant<=0, go to IDLE.
- Latency: request seen in IDLE cycle N gives oReq high in N+1. iDone in cycle M gives the done pulse in M+1 and IDLE in M+2, so the next grant is at M+3 at the earliest.
- iDone in IDLE or DONE is ignored.
- A request dropped mid-operation is ignored; the operation completes and done still pulses.
- Simultaneous pend and client request in IDLE: refresh wins. The client is served after refresh, with ptr unchanged.
- NUM_CH=1: ptr is constant 0.
- oReq is always zero- or one-hot. oGrant is one-hot or zero.

Optional Feature:
- Macro: ZSDRAM_REFRESH_POSTPONE_EN.
- Defined: in IDLE with pend and any client request, the client is served first while cnt < TREF+TPOSTPONE. Once cnt >= TREF+TPOSTPONE, refresh wins regardless of requests. With pend and no requests, refresh is issued immediately.
- Undefined: strict refresh priority at cnt >= TREF, and TPOSTPONE is unused.

Test Plan:
- Init: release rst, core pulses iDone at cycle 20 -> oReq=0001 for cycles 1..20, oReq=0000 at cycle 21, state IDLE, no grant.
- Single write, ch2 (NUM_CH=4): iWrReq=0100, iDone 5 cycles after oReq[3] rises -> oGrant=0100, oReq=1000, oWrDone=0100 for one cycle, oGrant cleared the next cycle.
- Round-robin: iRdReq=1111 held, iDone after 3 cycles each -> grant order ch0,ch1,ch2,ch3,ch0; each oRdDone pulses once per grant.
- Same-channel conflict: iWrReq[1]=iRdReq[1]=1 -> write served first (oReq=1000), then read on a later grant.
- Refresh, idle bus: no requests -> oReq=0010 asserted 601 cycles after INIT exit; clients blocked until iDone; counter restarts.
- Refresh contention: iWrReq=0001 continuous with TREF reached -> macro off: refresh before next write. Macro on: writes continue until cnt>=800, then refresh forced.
- Reset during WRITE (oReq=1000) -> all outputs 0 immediately, no oWrDone, INIT re-entered.
